// File: rtl/er_frame_pa_dispatcher.sv
// Snoops the reconciled-key BRAM write port, gates each reconciled frame on ER outcome and QBER,
// computes its secure key length and queues a descriptor for the privacy-amplification stage.
module er_frame_pa_dispatcher #(
    parameter int ADDR_W       = 15,
    parameter int WORD_W       = 64,
    parameter int LEAK_W       = 17,
    parameter int ERR_W        = 15,
    parameter int FRAME_WORDS  = 512,
    parameter int QBER_MAX_ERR = 1638,
    parameter int SEC_MARGIN   = 512,
    parameter int DESC_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_ena,
    input  logic              key_wea,
    input  logic [ADDR_W-1:0] key_addra,
    input  logic [LEAK_W-1:0] er_leaked_info,
    input  logic [ERR_W-1:0]  er_error_count,
    input  logic              er_parameter_valid,
    input  logic              er_verification_fail,
    input  logic              er_finish,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [ADDR_W-1:0] desc_base_addr,
    output logic [15:0]       desc_secure_len,
    output logic [ERR_W-1:0]  desc_error_count,
    output logic              frame_accepted,
    output logic              frame_dropped,
    output logic [2:0]        drop_reason,
    output logic              protocol_err
);

    localparam int CNT_W      = ADDR_W + 1;
    localparam int FRAME_BITS = FRAME_WORDS * WORD_W;
    localparam int PTR_W      = $clog2(DESC_DEPTH);

    localparam logic [2:0] R_VFAIL    = 3'd1;
    localparam logic [2:0] R_NOPARAM  = 3'd2;
    localparam logic [2:0] R_LENGTH   = 3'd3;
    localparam logic [2:0] R_ADDR     = 3'd4;
    localparam logic [2:0] R_QBER     = 3'd5;
    localparam logic [2:0] R_SHORTKEY = 3'd6;
    localparam logic [2:0] R_FULL     = 3'd7;

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, CALC} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [15:0]       len;
        logic [ERR_W-1:0]  err;
    } desc_t;

    state_t state, state_next;

    logic              wr;
    logic              collecting;
    logic              verdict;
    logic [ADDR_W-1:0] base_addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [CNT_W-1:0]  wcnt_q;
    logic              addr_err_q;
    logic [LEAK_W-1:0] leaked_q;
    logic [ERR_W-1:0]  err_q;
    logic              params_seen_q;
    logic              vfail_q;
    logic [2:0]        chk_reason;
    logic [17:0]       sec_len;
    logic              len_bad;

    logic [PTR_W:0]    wr_ptr, rd_ptr;
    desc_t             mem [DESC_DEPTH];
    desc_t             head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    assign wr         = key_ena && key_wea;
    assign collecting = (state == IDLE) || (state == COLLECT);
    assign verdict    = (state == CALC) || ((state == CHECK) && (chk_reason != 3'd0));

    // Per-frame bookkeeping; cleared on reset and on every verdict so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (rst || verdict) begin
            base_addr_q   <= '0;
            last_addr_q   <= '0;
            wcnt_q        <= '0;
            addr_err_q    <= 1'b0;
            leaked_q      <= '0;
            err_q         <= '0;
            params_seen_q <= 1'b0;
            vfail_q       <= 1'b0;
        end else if (collecting) begin
            if (wr) begin
                if (state == IDLE) begin
                    base_addr_q <= key_addra;
                    wcnt_q      <= CNT_W'(1);
                end else begin
                    if (wcnt_q != '1)
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    if (key_addra != last_addr_q + ADDR_W'(1))
                        addr_err_q <= 1'b1;
                end
                last_addr_q <= key_addra;
            end
            if (er_parameter_valid) begin
                leaked_q      <= er_leaked_info;
                err_q         <= er_error_count;
                params_seen_q <= 1'b1;
            end
            if (er_finish)
                vfail_q <= er_verification_fail;
        end
    end

    always_comb begin
        chk_reason = 3'd0;
        if (vfail_q)
            chk_reason = R_VFAIL;
        else if (!params_seen_q)
            chk_reason = R_NOPARAM;
        else if (wcnt_q != CNT_W'(FRAME_WORDS))
            chk_reason = R_LENGTH;
        else if (addr_err_q)
            chk_reason = R_ADDR;
        else if (err_q > ERR_W'(QBER_MAX_ERR))
            chk_reason = R_QBER;
    end

    // Signed 18-bit result: a negative or zero length means ER leaked away the whole key.
    assign sec_len = 18'(FRAME_BITS) - 18'(leaked_q) - 18'(SEC_MARGIN);
    assign len_bad = sec_len[17] || (sec_len == 18'd0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        frame_accepted = 1'b0;
        frame_dropped  = 1'b0;
        drop_reason    = 3'd0;
        protocol_err   = 1'b0;
        push           = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (er_finish)
                        state_next = CHECK;
                    else if (wr)
                        state_next = COLLECT;
                end
                COLLECT: begin
                    if (er_finish)
                        state_next = CHECK;
                end
                CHECK: begin
                    protocol_err = wr;
                    if (chk_reason != 3'd0) begin
                        state_next    = IDLE;
                        frame_dropped = 1'b1;
                        drop_reason   = chk_reason;
                    end else begin
                        state_next = CALC;
                    end
                end
                CALC: begin
                    protocol_err = wr;
                    state_next   = IDLE;
                    if (len_bad) begin
                        frame_dropped = 1'b1;
                        drop_reason   = R_SHORTKEY;
                    end else if (fifo_full && !pop) begin
                        frame_dropped = 1'b1;
                        drop_reason   = R_FULL;
                    end else begin
                        frame_accepted = 1'b1;
                        push           = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // First-word-fall-through descriptor queue; the extra pointer bit tells full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = mem[rd_ptr[PTR_W-1:0]];
    assign desc_valid = !fifo_empty && !rst;
    assign pop        = desc_valid && desc_ready;

    assign desc_base_addr   = desc_valid ? head.base : '0;
    assign desc_secure_len  = desc_valid ? head.len  : '0;
    assign desc_error_count = desc_valid ? head.err  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= '{base: base_addr_q, len: sec_len[15:0], err: err_q};
    end

endmodule

// File: tb/tb_er_frame_pa_dispatcher.sv
// Self-checking bench for er_frame_pa_dispatcher: a table of whole frames with expected verdicts,
// plus hand-written stall, reset and protocol sequences; descriptors are checked via a scoreboard.
module tb_er_frame_pa_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ena;
    logic        key_wea;
    logic [14:0] key_addra;
    logic [16:0] er_leaked_info;
    logic [14:0] er_error_count;
    logic        er_parameter_valid;
    logic        er_verification_fail;
    logic        er_finish;
    logic        desc_valid;
    logic        desc_ready;
    logic [14:0] desc_base_addr;
    logic [15:0] desc_secure_len;
    logic [14:0] desc_error_count;
    logic        frame_accepted;
    logic        frame_dropped;
    logic [2:0]  drop_reason;
    logic        protocol_err;

    er_frame_pa_dispatcher dut (
        .clk                  (clk),
        .rst                  (rst),
        .key_ena              (key_ena),
        .key_wea              (key_wea),
        .key_addra            (key_addra),
        .er_leaked_info       (er_leaked_info),
        .er_error_count       (er_error_count),
        .er_parameter_valid   (er_parameter_valid),
        .er_verification_fail (er_verification_fail),
        .er_finish            (er_finish),
        .desc_valid           (desc_valid),
        .desc_ready           (desc_ready),
        .desc_base_addr       (desc_base_addr),
        .desc_secure_len      (desc_secure_len),
        .desc_error_count     (desc_error_count),
        .frame_accepted       (frame_accepted),
        .frame_dropped        (frame_dropped),
        .drop_reason          (drop_reason),
        .protocol_err         (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nwords;
        logic [14:0] base;
        int          skip_at;
        logic [16:0] leaked;
        logic [14:0] err;
        bit          params;
        bit          vfail;
        bit          poke;
        int          exp_reason;
        logic [15:0] exp_len;
    } vec_t;

    typedef struct packed {
        logic [14:0] base;
        logic [15:0] len;
        logic [14:0] err;
    } exp_desc_t;

    vec_t      vecs[$];
    exp_desc_t exp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int verdict_cnt = 0;
    int verdict_cyc = 0;
    int last_reason = -1;
    int prot_cnt = 0;
    int pop_cnt = 0;
    int finish_cyc = 0;
    int vcnt_before = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Verdict/descriptor monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        exp_desc_t e;
        if (frame_accepted || frame_dropped) begin
            verdict_cnt++;
            verdict_cyc = cyc;
            last_reason = frame_dropped ? int'(drop_reason) : 0;
            if (frame_accepted && frame_dropped)
                checkOutput("both_pulses", 1, 0);
            if (frame_accepted)
                checkOutput("reason_on_accept", drop_reason, 0);
        end
        if (protocol_err)
            prot_cnt++;
        if (desc_valid && desc_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_desc", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("desc_base", desc_base_addr, e.base);
                checkOutput("desc_len", desc_secure_len, e.len);
                checkOutput("desc_err", desc_error_count, e.err);
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.nwords; i++) begin
            @(posedge clk); #1;
            key_ena   = 1'b1;
            key_wea   = 1'b1;
            key_addra = v.base + 15'(i) + (((v.skip_at >= 0) && (i >= v.skip_at)) ? 15'd1 : 15'd0);
        end
        @(posedge clk); #1;
        key_ena = 1'b0;
        key_wea = 1'b0;
        if (v.params) begin
            er_parameter_valid = 1'b1;
            er_leaked_info     = v.leaked;
            er_error_count     = v.err;
        end
        @(posedge clk); #1;
        er_parameter_valid   = 1'b0;
        er_finish            = 1'b1;
        er_verification_fail = v.vfail;
        finish_cyc           = cyc;
        vcnt_before          = verdict_cnt;
        if (v.exp_reason == 0)
            exp_q.push_back('{base: v.base, len: v.exp_len, err: v.err});
        @(posedge clk); #1;
        er_finish            = 1'b0;
        er_verification_fail = 1'b0;
        if (v.poke) begin
            key_ena   = 1'b1;
            key_wea   = 1'b1;
            key_addra = 15'h1234;
            @(negedge clk); #1;
            checkOutput("protocol_err_in_check", protocol_err, 1);
            key_ena = 1'b0;
            key_wea = 1'b0;
        end
    endtask

    task automatic wait_verdict(input vec_t v);
        int exp_lat;
        exp_lat = ((v.exp_reason >= 1) && (v.exp_reason <= 5)) ? 1 : 2;
        for (int k = 0; (k < 8) && (verdict_cnt == vcnt_before); k++) begin
            @(negedge clk); #1;
        end
        checkOutput("verdict_seen", verdict_cnt, vcnt_before + 1);
        if (verdict_cnt == vcnt_before + 1) begin
            checkOutput("verdict_reason", last_reason, v.exp_reason);
            checkOutput("verdict_latency", verdict_cyc - finish_cyc, exp_lat);
        end
        if (v.exp_reason == 0) begin
            @(negedge clk); #1;
            checkOutput("desc_valid_after_accept", desc_valid, 1);
        end
    endtask

    vec_t good;
    vec_t fv;
    int   pops_before;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        key_ena = 1'b0;
        key_wea = 1'b0;
        key_addra = '0;
        er_leaked_info = '0;
        er_error_count = '0;
        er_parameter_valid = 1'b0;
        er_verification_fail = 1'b0;
        er_finish = 1'b0;
        desc_ready = 1'b1;

        good = '{512, 15'h0000, -1, 17'd5000, 15'd200, 1'b1, 1'b0, 1'b0, 0, 16'd27256};
        vecs.push_back(good);
        vecs.push_back('{512, 15'h0000, -1, 17'd5000, 15'd200, 1'b1, 1'b1, 1'b0, 1, 16'd0});
        vecs.push_back('{512, 15'h0000, -1, 17'd5000, 15'd200, 1'b0, 1'b0, 1'b0, 2, 16'd0});
        vecs.push_back('{511, 15'h0000, -1, 17'd5000, 15'd200, 1'b1, 1'b0, 1'b0, 3, 16'd0});
        vecs.push_back('{512, 15'h0000,  5, 17'd5000, 15'd200, 1'b1, 1'b0, 1'b0, 4, 16'd0});
        vecs.push_back('{512, 15'h0000, -1, 17'd5000, 15'd1700, 1'b1, 1'b0, 1'b0, 5, 16'd0});
        vecs.push_back('{512, 15'h0000, -1, 17'd32300, 15'd200, 1'b1, 1'b0, 1'b0, 6, 16'd0});
        vecs.push_back('{512, 15'h7F00, -1, 17'd1000, 15'd0, 1'b1, 1'b0, 1'b0, 0, 16'd31256});
        vecs.push_back('{512, 15'h0200, -1, 17'd32255, 15'd1638, 1'b1, 1'b0, 1'b0, 0, 16'd1});
        vecs.push_back('{512, 15'h0400, -1, 17'd32256, 15'd10, 1'b1, 1'b0, 1'b0, 6, 16'd0});
        vecs.push_back('{512, 15'h0600, -1, 17'd7000, 15'd33, 1'b1, 1'b0, 1'b1, 0, 16'd25256});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_outputs",
                    {desc_valid, frame_accepted, frame_dropped, drop_reason, protocol_err,
                     desc_base_addr, desc_secure_len, desc_error_count}, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            wait_verdict(vecs[i]);
        end
        repeat (4) @(negedge clk);
        #1 checkOutput("table_queue_drained", exp_q.size(), 0);

        // Stalled consumer: four frames fill the queue, the fifth must be refused.
        @(posedge clk); #1 desc_ready = 1'b0;
        pops_before = pop_cnt;
        for (int f = 0; f < 5; f++) begin
            fv = good;
            fv.base = 15'(f * 512);
            fv.err = 15'(10 + f);
            fv.exp_reason = (f < 4) ? 0 : 7;
            applyStimulus(fv);
            wait_verdict(fv);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checkOutput("stall_valid", desc_valid, 1);
            checkOutput("stall_base", desc_base_addr, exp_q[0].base);
            checkOutput("stall_err", desc_error_count, exp_q[0].err);
        end
        @(posedge clk); #1 desc_ready = 1'b1;
        for (int k = 0; (k < 20) && (exp_q.size() != 0); k++) begin
            @(negedge clk); #1;
        end
        checkOutput("stall_drained_count", pop_cnt - pops_before, 4);
        @(negedge clk); #1;
        checkOutput("stall_empty_after", desc_valid, 0);

        // Reset in the middle of a frame discards it silently.
        vcnt_before = verdict_cnt;
        pops_before = pop_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            key_ena   = 1'b1;
            key_wea   = 1'b1;
            key_addra = 15'(i);
        end
        @(posedge clk); #1;
        key_ena = 1'b0;
        key_wea = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("reset_no_verdict", verdict_cnt, vcnt_before);
        checkOutput("reset_no_desc", pop_cnt - pops_before + int'(desc_valid), 0);
        applyStimulus(good);
        wait_verdict(good);

        repeat (4) @(negedge clk);
        #1;
        checkOutput("final_queue_drained", exp_q.size(), 0);
        checkOutput("protocol_err_count", prot_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
